rx_fifo_sync: RTL

//  Single-clock receive-side FIFO: the read-out end of a dp_ram buffer. Accepts bytes via valid/ready on
//  the write side, stores them in a dp_ram instance, and presents them on a registered

---
 rtl/rx_fifo_sync_pkg.sv | 29 ++
 rtl/rx_fifo_sync_dp_ram.sv | 36 +++
 rtl/rx_fifo_sync.sv | 102 ++++++++++
 3 files changed

// File: rtl/rx_fifo_sync_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rx_fifo_sync_pkg
// Brief    : Constants and helpers shared by the tx/rx FIFOs.
// Revision : 1.0
// ============================================================================
package rx_fifo_sync_pkg;

    localparam int c_DEF_DATA_WIDTH   = 8;
    localparam int c_DEF_ADDR_WIDTH   = 4;
    localparam int c_DEF_AFULL_THRESH = 12;

    typedef enum logic [1:0] {
        FIFO_EMPTY   = 2'd0,
        FIFO_PARTIAL = 2'd1,
        FIFO_FULL    = 2'd2
    } fifo_level_e;

    function automatic int ram_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    // One extra pointer bit distinguishes full from empty on equal addresses.
    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rx_fifo_sync_dp_ram.sv
`default_nettype none
// ============================================================================
// Module   : rx_fifo_sync_dp_ram
// Brief    : Simple dual-port RAM, clocked write, combinational read.
// Revision : 1.0
// ============================================================================
module rx_fifo_sync_dp_ram
    import rx_fifo_sync_pkg::*;
#(
    parameter int DATA_WIDTH = c_DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = c_DEF_ADDR_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_wen,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_ren,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    localparam int c_DEPTH = ram_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];

    // Contents are deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (i_wen) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = i_ren ? r_mem[i_raddr] : '0;

endmodule
`default_nettype wire

// File: rtl/rx_fifo_sync.sv
`default_nettype none
// ============================================================================
// Module   : rx_fifo_sync
// Brief    : Single-clock RX FIFO with registered FWFT read port.
// Revision : 1.0
// ============================================================================
module rx_fifo_sync
    import rx_fifo_sync_pkg::*;
#(
    parameter int DATA_WIDTH   = c_DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH   = c_DEF_ADDR_WIDTH,
    parameter int AFULL_THRESH = c_DEF_AFULL_THRESH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr_valid,
    output logic                  o_wr_ready,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic                  o_rd_valid,
    input  logic                  i_rd_ready,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic [ADDR_WIDTH:0]   o_count,
    output logic                  o_afull,
    output logic                  o_empty
);

    localparam int c_PTR_W = ptr_width(ADDR_WIDTH);

    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic                  r_rd_valid;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic [c_PTR_W-1:0]    r_count;
    logic                  r_afull;
    logic                  r_empty;

    logic                  w_ram_empty;
    logic                  w_ram_full;
    logic                  w_wr_fire;
    logic                  w_rd_fire;
    logic                  w_load;
    logic [DATA_WIDTH-1:0] w_ram_rdata;
    logic [c_PTR_W-1:0]    w_count_nxt;

    assign w_ram_empty = (r_wr_ptr == r_rd_ptr);
    assign w_ram_full  = (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]) &&
                         (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]);

    assign w_wr_fire   = i_wr_valid & ~w_ram_full;
    assign w_rd_fire   = r_rd_valid & i_rd_ready;
    // Empty test uses the pre-write pointer, so a same-cycle write loads next cycle.
    assign w_load      = ~w_ram_empty & (~r_rd_valid | i_rd_ready);
    assign w_count_nxt = r_count + c_PTR_W'(w_wr_fire) - c_PTR_W'(w_rd_fire);

    rx_fifo_sync_dp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_dp_ram (
        .i_clk   (i_clk),
        .i_wen   (w_wr_fire & ~i_rst),
        .i_waddr (r_wr_ptr[ADDR_WIDTH-1:0]),
        .i_wdata (i_wr_data),
        .i_ren   (1'b1),
        .i_raddr (r_rd_ptr[ADDR_WIDTH-1:0]),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_count    <= '0;
            r_afull    <= 1'b0;
            r_empty    <= 1'b1;
        end else begin
            if (w_wr_fire) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_load) begin
                r_rd_data  <= w_ram_rdata;
                r_rd_ptr   <= r_rd_ptr + 1'b1;
                r_rd_valid <= 1'b1;
            end else if (w_rd_fire) begin
                r_rd_valid <= 1'b0;
            end
            r_count <= w_count_nxt;
            r_afull <= (w_count_nxt >= c_PTR_W'(AFULL_THRESH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    assign o_wr_ready = ~w_ram_full;
    assign o_rd_valid = r_rd_valid;
    assign o_rd_data  = r_rd_data;
    assign o_count    = r_count;
    assign o_afull    = r_afull;
    assign o_empty    = r_empty;

endmodule
`default_nettype wire
